cdb_arbiter: RTL and testbench



---
 rtl/cdb_pkg.sv | 24 ++
 rtl/cdb_arbiter_rr_multi_grant.sv | 54 +++++
 rtl/cdb_arbiter.sv | 87 ++++++++
 tb/tb_cdb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB arbitration types and constants.
// Imported by the arbiter and its grant selector.
package cdb_pkg;

    localparam int CDB_NUM_CH  = 4;
    localparam int CDB_NUM_REQ = 5;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_PREG_W  = 6;
    localparam int CDB_TAG_W   = 3;

    localparam logic [CDB_TAG_W-1:0] SRC_ALU0 = 3'd0;
    localparam logic [CDB_TAG_W-1:0] SRC_ALU1 = 3'd1;
    localparam logic [CDB_TAG_W-1:0] SRC_ALU2 = 3'd2;
    localparam logic [CDB_TAG_W-1:0] SRC_LSQ  = 3'd3;
    localparam logic [CDB_TAG_W-1:0] SRC_MDU  = 3'd4;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_PREG_W-1:0] dest_reg;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Rotating-priority selector granting up to NUM_CH of NUM_REQ requesters.
// Winners are packed onto channels in scan order starting at ptr_i.
module rr_multi_grant
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int NUM_CH  = CDB_NUM_CH
) (
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [2:0]                   ptr_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_CH-1:0]            ch_valid_o,
    output logic [NUM_CH-1:0][2:0]       ch_src_o,
    output logic [2:0]                   next_ptr_o
);

    localparam int CW = $clog2(NUM_CH);

    logic [2:0]  idx;
    logic [2:0]  last;
    logic [CW:0] cnt;
    logic        denied;

    always_comb begin
        gnt_o      = '0;
        ch_valid_o = '0;
        ch_src_o   = '0;
        idx        = ptr_i;
        last       = ptr_i;
        cnt        = '0;
        denied     = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (req_i[idx]) begin
                if (cnt < (CW+1)'(NUM_CH)) begin
                    gnt_o[idx]               = 1'b1;
                    ch_valid_o[cnt[CW-1:0]]  = 1'b1;
                    ch_src_o[cnt[CW-1:0]]    = idx;
                    last                     = idx;
                    cnt                      = cnt + 1'b1;
                end else begin
                    denied = 1'b1;
                end
            end
            idx = (idx == 3'(NUM_REQ-1)) ? 3'd0 : idx + 3'd1;
        end
        // Restart after the last winner only when someone lost this round
        if (denied) begin
            next_ptr_o = (last == 3'(NUM_REQ-1)) ? 3'd0 : last + 3'd1;
        end else begin
            next_ptr_o = ptr_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants up to four producers per cycle and
// registers the winners onto CDB channels 0-3 for the following cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_WIDTH          = CDB_DATA_W,
    parameter int PHYS_REG_ADDR_WIDTH = CDB_PREG_W,
    parameter int NUM_REQ             = CDB_NUM_REQ,
    parameter int NUM_CH              = CDB_NUM_CH
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]            req_data,
    input  logic [NUM_REQ-1:0][PHYS_REG_ADDR_WIDTH-1:0]   req_dest_reg,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic [NUM_CH-1:0]                             cdb_valid,
    output logic [NUM_CH-1:0][2:0]                        cdb_tag,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]             cdb_data,
    output logic [NUM_CH-1:0][PHYS_REG_ADDR_WIDTH-1:0]    cdb_dest_reg
);

    logic [2:0]                                   prio_ptr_q, prio_ptr_d;
    logic [NUM_CH-1:0]                            valid_q, valid_d;
    logic [NUM_CH-1:0][2:0]                       tag_q, tag_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]            data_q, data_d;
    logic [NUM_CH-1:0][PHYS_REG_ADDR_WIDTH-1:0]   dest_q, dest_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0][2:0]  ch_src;
    logic [2:0]              next_ptr;

    rr_multi_grant #(
        .NUM_REQ (NUM_REQ),
        .NUM_CH  (NUM_CH)
    ) u_sel (
        .req_i      (req_valid),
        .ptr_i      (prio_ptr_q),
        .gnt_o      (gnt),
        .ch_valid_o (ch_valid),
        .ch_src_o   (ch_src),
        .next_ptr_o (next_ptr)
    );

    assign req_ready = (reset || flush) ? '0 : gnt;

    always_comb begin
        valid_d    = '0;
        tag_d      = tag_q;
        data_d     = data_q;
        dest_d     = dest_q;
        prio_ptr_d = flush ? prio_ptr_q : next_ptr;
        // Payload fields hold on idle channels; consumers qualify with valid
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_valid[k] && !flush) begin
                valid_d[k] = 1'b1;
                tag_d[k]   = ch_src[k];
                data_d[k]  = req_data[ch_src[k]];
                dest_d[k]  = req_dest_reg[ch_src[k]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_ptr_q <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            dest_q     <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
        end
    end

    assign cdb_valid    = valid_q;
    assign cdb_tag      = tag_q;
    assign cdb_data     = data_q;
    assign cdb_dest_reg = dest_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_cdb_arbiter;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [4:0]            req_valid;
    logic [4:0][31:0]      req_data;
    logic [4:0][5:0]       req_dest_reg;
    logic [4:0]            req_ready;
    logic [3:0]            cdb_valid;
    logic [3:0][2:0]       cdb_tag;
    logic [3:0][31:0]      cdb_data;
    logic [3:0][5:0]       cdb_dest_reg;

    int checks = 0;
    int errors = 0;

    int          m_prio = 0;
    logic [3:0]  m_val = '0;
    logic [2:0]  m_tag [4] = '{default: '0};
    logic [31:0] m_data [4] = '{default: '0};
    logic [5:0]  m_dest [4] = '{default: '0};
    logic [4:0]  m_gnt_last = '0;

    cdb_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_dest_reg (req_dest_reg),
        .req_ready    (req_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_dest_reg (cdb_dest_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scan list of valid requesters starting at p; first four win.
    function automatic void model_grant(input logic [4:0] v, input int p,
                                        output logic [4:0] g,
                                        output logic [3:0][2:0] src,
                                        output int ng, output int np);
        int q[$];
        for (int n = 0; n < 5; n++) begin
            int i = (p + n) % 5;
            if (v[i]) q.push_back(i);
        end
        ng  = (q.size() > 4) ? 4 : q.size();
        g   = '0;
        src = '0;
        for (int n = 0; n < ng; n++) begin
            g[q[n]] = 1'b1;
            src[n]  = 3'(q[n]);
        end
        np = (q.size() > 4) ? (q[3] + 1) % 5 : p;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prio     = 0;
            m_val      = '0;
            m_gnt_last = '0;
            for (int k = 0; k < 4; k++) begin
                m_tag[k] = '0; m_data[k] = '0; m_dest[k] = '0;
            end
        end else begin
            logic [4:0]      g;
            logic [3:0][2:0] src;
            int              ng, np;
            model_grant(req_valid, m_prio, g, src, ng, np);
            m_val = '0;
            if (flush) begin
                m_gnt_last = '0;
            end else begin
                m_gnt_last = g;
                m_prio     = np;
                for (int n = 0; n < ng; n++) begin
                    m_val[n]  = 1'b1;
                    m_tag[n]  = src[n];
                    m_data[n] = req_data[src[n]];
                    m_dest[n] = req_dest_reg[src[n]];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]      g;
        logic [3:0][2:0] src;
        int              ng, np;
        model_grant(req_valid, m_prio, g, src, ng, np);
        if (reset || flush) g = '0;
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("cdb_valid", 64'(cdb_valid), 64'(m_val));
        chk("prio_ptr", 64'(dut.prio_ptr_q), 64'(m_prio));
        for (int k = 0; k < 4; k++) begin
            chk("cdb_tag", 64'(cdb_tag[k]), 64'(m_tag[k]));
            chk("cdb_data", 64'(cdb_data[k]), 64'(m_data[k]));
            chk("cdb_dest", 64'(cdb_dest_reg[k]), 64'(m_dest[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input int i);
        req_data[i]     = $urandom;
        req_dest_reg[i] = 6'($urandom);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 5'b11111;
        for (int i = 0; i < 5; i++) rand_payload(i);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(cdb_valid), 64'h0);
        reset = 1'b0;
        #1;
        chk("first_ready", 64'(req_ready), 64'b01111);
        tick();
        chk("first_valid", 64'(cdb_valid), 64'hF);
        chk("first_tags", 64'(cdb_tag), 64'({3'd3, 3'd2, 3'd1, 3'd0}));
        chk("first_prio", 64'(dut.prio_ptr_q), 64'd4);
        for (int i = 0; i < 4; i++) rand_payload(i);
        chk("second_ready", 64'(req_ready), 64'b10111);
        tick();
        chk("second_tags", 64'(cdb_tag), 64'({3'd2, 3'd1, 3'd0, 3'd4}));
        chk("second_prio", 64'(dut.prio_ptr_q), 64'd3);

        req_valid       = 5'b01000;
        req_data[3]     = 32'hDEADBEEF;
        req_dest_reg[3] = 6'd17;
        #1;
        chk("lsq_ready", 64'(req_ready), 64'b01000);
        tick();
        chk("lsq_valid", 64'(cdb_valid), 64'b0001);
        chk("lsq_tag", 64'(cdb_tag[0]), 64'd3);
        chk("lsq_data", 64'(cdb_data[0]), 64'hDEADBEEF);
        chk("lsq_dest", 64'(cdb_dest_reg[0]), 64'd17);
        chk("lsq_prio", 64'(dut.prio_ptr_q), 64'd3);

        req_valid = 5'b11111;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        chk("rp_prio", 64'(dut.prio_ptr_q), 64'd4);
        req_valid = 5'b10101;
        #1;
        chk("wrap_ready", 64'(req_ready), 64'b10101);
        tick();
        chk("wrap_valid", 64'(cdb_valid), 64'b0111);
        chk("wrap_tag0", 64'(cdb_tag[0]), 64'd4);
        chk("wrap_tag1", 64'(cdb_tag[1]), 64'd0);
        chk("wrap_tag2", 64'(cdb_tag[2]), 64'd2);
        chk("wrap_prio", 64'(dut.prio_ptr_q), 64'd4);

        req_valid = 5'b11111;
        tick();
        chk("pre_flush_valid", 64'(cdb_valid), 64'hF);
        chk("pre_flush_prio", 64'(dut.prio_ptr_q), 64'd3);
        flush     = 1'b1;
        req_valid = 5'b01011;
        #1;
        chk("flush_ready", 64'(req_ready), 64'h0);
        tick();
        chk("flush_valid", 64'(cdb_valid), 64'h0);
        chk("flush_prio", 64'(dut.prio_ptr_q), 64'd3);
        flush = 1'b0;
        #1;
        chk("post_flush_ready", 64'(req_ready), 64'b01011);
        tick();
        chk("post_flush_valid", 64'(cdb_valid), 64'b0111);
        chk("post_flush_tags", 64'(cdb_tag[2:0]), 64'({3'd1, 3'd0, 3'd3}));

        req_valid = 5'b11111;
        tick();
        chk("mid_pre_valid", 64'(cdb_valid), 64'hF);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(cdb_valid), 64'h0);
        chk("mid_rst_prio", 64'(dut.prio_ptr_q), 64'd0);
        reset = 1'b0;

        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < 5; i++) begin
                if (!req_valid[i] || m_gnt_last[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    rand_payload(i);
                end
            end
            flush = ($urandom_range(0, 9) == 0);
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
